data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised single-port data memory with a valid/ready request channel, configurable read latency and a hardware init sequencer. After reset the sequencer sweeps the array: it zeroes every word and loads a preset ramp window (value 1, 2, 3, … from a base address). It replaces the fixed 32-entry testbench-initialised data memory in the multicycle datapath and serves the controller's load/store cycles.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of implemented words; must be 2..2^ADDR_W
RD_LAT, 1, read latency in cycles from acceptance to rsp_valid; must be 1..4
PRESET_BASE, 10, first address of the preset ramp
PRESET_CNT, 10, ramp length; 0 disables the ramp; PRESET_BASE+PRESET_CNT must be <= DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted on the edge where valid and ready are both high
req_we  in  1  1 = write, 0 = read
req_adr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  DATA_W  read data; held until the next response
init_done  out  1  high once the init sweep has finished
parity_err  out  1  only with MEM_PARITY_EN; qualifies rsp_valid

Behaviour:
- Reset (rst=0 at an edge): state moves to INIT; init counter=0; req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, parity_err=0. Any in-flight read is dropped and produces no response.
- INIT: one word is written per cycle at address cnt.
  - Value is cnt-PRESET_BASE+1, truncated to DATA_W, if cnt is in [PRESET_BASE, PRESET_BASE+PRESET_CNT). Otherwise the value is 0.
  - After word DEPTH-1 is written: init_done=1 and the state moves to IDLE. The sweep takes exactly DEPTH cycles.
  - Requests are ignored during INIT because req_ready=0.
- IDLE: req_ready=1.
  - Write accepted: mem[adr] updates at the accepting edge. No response. State stays IDLE, so back-to-back writes run one per cycle.
  - Read accepted: adr is captured.
    - RD_LAT=1: rsp_valid=1 in the next cycle and the state stays IDLE, so back-to-back reads run one per cycle.
    - RD_LAT>1: state moves to RD_WAIT, with a down-counter loaded with RD_LAT-1.
- RD_WAIT: req_ready=0. The counter decrements each cycle. On the edge where the counter reaches 0, rsp_valid=1 for one cycle and the state returns to IDLE, where req_ready=1 in the same cycle as rsp_valid.
- Read data is the array content at the accepting edge. A write to the same address accepted in the same cycle is impossible (single port). A later write cannot occur before the response, because req_ready=0 in RD_WAIT.
- Out of range (adr >= DEPTH): writes are dropped silently. Reads complete with normal latency and return 0.
- rsp_rdata changes only when rsp_valid pulses.
- Reset mid-INIT restarts the sweep from address 0. Reset mid-RD_WAIT aborts the read.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, generated on every write including init writes.
  - On a read, parity_err=1 alongside rsp_valid if the stored parity mismatches the stored data. Otherwise parity_err=0.
  - Out-of-range reads report parity_err=0.
  - A hidden-state inject hook (bench hierarchical force on the parity array) must be reachable.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package mem_pkg:
  - state enum {INIT, IDLE, RD_WAIT}
  - clog2-derived counter width constant
  - preset-value function preset_val(idx)
  - parity function par(data)
- One sub-module, mem_array_sp: a synchronous-write, registered-read single-port array (DATA_W+parity, DEPTH). The controller FSM and latency pipe stay in data_mem_ctrl.

Test Plan:
1. Defaults, release rst after 3 cycles -> init_done rises exactly 32 cycles later; reads 0..31 return 0 except adr 10..19, which return 1..10.
2. RD_LAT=1, write adr 5 = 0xA5, then read adr 5 in the next cycle -> rsp_valid the cycle after acceptance, rdata 0xA5; back-to-back reads of 10, 11 return 1, 2 on consecutive cycles.
3. RD_LAT=3, read adr 12 -> req_ready low for 2 cycles, rsp_valid 3 cycles after acceptance with rdata 3; the next request is accepted in the rsp_valid cycle.
4. DEPTH=20, ADDR_W=5, write adr 25 = 0x77, then read adr 25 -> rdata 0; adr 19 is unchanged at 10.
5. Assert rst for 1 cycle during RD_WAIT and again at init cycle 7 -> no rsp_valid is produced, and the sweep restarts so init_done rises DEPTH cycles after the last rst release.
6. With MEM_PARITY_EN, force the parity bit of adr 14 and read it -> rdata 5, parity_err=1; a read of adr 15 gives rdata 6 with parity_err=0.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller (package mem_pkg).
// Provides the FSM state type, latency-counter width, preset ramp and parity functions.
package mem_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  localparam int RD_LAT_MAX = 4;
  // Latency down-counter only ever holds RD_LAT-1, at most RD_LAT_MAX-1.
  localparam int LAT_W      = $clog2(RD_LAT_MAX);
  localparam int PAR_MAX_W  = 64;

  function automatic int preset_val(input int idx, input int base, input int cnt);
    return (idx >= base && idx < base + cnt) ? idx - base + 1 : 0;
  endfunction

  function automatic logic par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response channel between the datapath controller and the data memory.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_adr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_array_sp.sv
// Single-port array: synchronous write, registered read, out-of-range reads return 0.
// With MEM_PARITY_EN each word carries an even-parity bit in par_mem.
module mem_array_sp
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
`ifdef MEM_PARITY_EN
  ,
  output logic              rpar
`endif
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = {1'b0, adr} < DEPTH_L;

  always_ff @(posedge clk) begin
    if (we && in_range) mem[adr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= in_range ? mem[adr] : '0;
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && in_range) par_mem[adr] <= par(PAR_MAX_W'(wdata));
  end

  always_ff @(posedge clk) begin
    if (!rst)    rpar <= 1'b0;
    else if (re) rpar <= in_range ? par_mem[adr] : 1'b0;
  end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: init sweep (zero + preset ramp), valid/ready requests, RD_LAT read pipe.
// Optional parity checking is built when MEM_PARITY_EN is defined.
//
// state   | meaning
// INIT    | sweeping the array, one word per cycle, req_ready low
// IDLE    | accepting requests; RD_LAT=1 reads answer next cycle
// RD_WAIT | read in flight, latency counter running, req_ready low
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int RD_LAT      = 1,
  parameter int PRESET_BASE = 10,
  parameter int PRESET_CNT  = 10
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_ctrl_if.slave   bus,
  output logic             init_done
`ifdef MEM_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT - 1);

  state_e            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              rsp_valid_q;
  logic              rd_accept;
  logic              wr_accept;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_adr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_fire;
`ifdef MEM_PARITY_EN
  logic              arr_rpar;
  logic              rsp_par;
`endif

  assign bus.req_ready = (state == IDLE);
  assign rd_accept     = bus.req_ready & bus.req_valid & ~bus.req_we;
  assign wr_accept     = bus.req_ready & bus.req_valid &  bus.req_we;
  assign rsp_fire      = (state == RD_WAIT) && (lat_cnt == LAT_W'(1));

  always_comb begin
    arr_we    = wr_accept;
    arr_re    = rd_accept;
    arr_adr   = bus.req_adr;
    arr_wdata = bus.req_wdata;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_re    = 1'b0;
      arr_adr   = init_cnt;
      arr_wdata = DATA_W'(preset_val(int'(init_cnt), PRESET_BASE, PRESET_CNT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      lat_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == LAST_ADR) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rd_accept) begin
            if (RD_LAT == 1) begin
              rsp_valid_q <= 1'b1;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        RD_WAIT: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b1;
            state       <= IDLE;
            lat_cnt     <= '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  mem_array_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_arr (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .adr   (arr_adr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
`ifdef MEM_PARITY_EN
    ,
    .rpar  (arr_rpar)
`endif
  );

  // The array output register only loads on read accepts, so at RD_LAT=1 it is the response.
  if (RD_LAT == 1) begin : g_lat1
    assign rsp_data = arr_rdata;
`ifdef MEM_PARITY_EN
    assign rsp_par  = arr_rpar;
`endif
  end else begin : g_latn
    logic [DATA_W-1:0] hold_data;
    always_ff @(posedge clk) begin
      if (!rst)          hold_data <= '0;
      else if (rsp_fire) hold_data <= arr_rdata;
    end
    assign rsp_data = hold_data;
`ifdef MEM_PARITY_EN
    logic hold_par;
    always_ff @(posedge clk) begin
      if (!rst)          hold_par <= 1'b0;
      else if (rsp_fire) hold_par <= arr_rpar;
    end
    assign rsp_par = hold_par;
`endif
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_data;

`ifdef MEM_PARITY_EN
  assign parity_err = rsp_valid_q & (rsp_par ^ par(PAR_MAX_W'(rsp_data)));
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance a uses defaults (RD_LAT=1, DEPTH=32), instance b uses RD_LAT=3, DEPTH=20.
// Parity scenario is compiled in when MEM_PARITY_EN is defined.
module tb_data_mem_ctrl;

  logic clk;
  logic rst_a, rst_b;
  logic done_a, done_b;
`ifdef MEM_PARITY_EN
  logic perr_a, perr_b;
`endif

  data_mem_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus_a ();
  data_mem_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus_b ();

  data_mem_ctrl dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (bus_a),
    .init_done (done_a)
`ifdef MEM_PARITY_EN
    ,
    .parity_err(perr_a)
`endif
  );

  data_mem_ctrl #(.RD_LAT(3), .DEPTH(20)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (bus_b),
    .init_done (done_b)
`ifdef MEM_PARITY_EN
    ,
    .parity_err(perr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cur   = 1'b0;
  logic [7:0] mdl [2][32];

  logic       o_ready, o_rvalid, o_done;
  logic [7:0] o_rdata;
  always_comb begin
    o_ready  = cur ? bus_b.req_ready : bus_a.req_ready;
    o_rvalid = cur ? bus_b.rsp_valid : bus_a.rsp_valid;
    o_rdata  = cur ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    o_done   = cur ? done_b : done_a;
  end

  function automatic int dep_of(input bit s);
    return s ? 20 : 32;
  endfunction

  function automatic int lat_of(input bit s);
    return s ? 3 : 1;
  endfunction

  // Reference memory after an init sweep: ramp 1..10 at 10..19, zero elsewhere.
  task automatic model_init(input bit s);
    for (int i = 0; i < 32; i++)
      mdl[s][i] = (i < dep_of(s) && i >= 10 && i < 20) ? 8'(i - 9) : 8'h00;
  endtask

  task automatic drv(input bit v, input bit we, input logic [4:0] adr, input logic [7:0] wd);
    if (cur) begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_adr = adr; bus_b.req_wdata = wd;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_adr = adr; bus_a.req_wdata = wd;
    end
  endtask

  task automatic set_rst(input bit v);
    if (cur) rst_b = v; else rst_a = v;
  endtask

  // Call just after a negedge; returns after the accepting posedge with valid still driven.
  task automatic issue(input bit we, input logic [4:0] adr, input logic [7:0] wd, output bit ok);
    int n;
    n = 0;
    drv(1'b1, we, adr, wd);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = o_ready;
    if (!ok) begin
      drv(1'b0, 1'b0, 5'd0, 8'd0);
      return;
    end
    @(posedge clk);
  endtask

  // Counts cycles from acceptance to the response; request is dropped on the first negedge.
  task automatic wait_rsp(output int cyc, output logic [7:0] d);
    @(negedge clk);
    drv(1'b0, 1'b0, 5'd0, 8'd0);
    cyc = 1;
    while (!o_rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    d = o_rdata;
  endtask

  task automatic test_reset_init(input bit s);
    int n;
    bit bad_rdy, ok;
    int cyc;
    logic [7:0] d;
    cur = s;
    set_rst(1'b0);
    drv(1'b1, 1'b1, 5'd12, 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_ready, o_rvalid, o_done, o_rdata} !== 11'd0) begin
      bad++;
      $display("FAIL reset_state[%0d]: got rdy/vld/done/rdata=%b want all zero", s, {o_ready, o_rvalid, o_done, o_rdata});
    end
    set_rst(1'b1);
    n = 0;
    bad_rdy = 1'b0;
    while (!o_done && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!o_done && o_ready) bad_rdy = 1'b1;
    end
    drv(1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (n !== dep_of(s)) begin
      bad++;
      $display("FAIL init_cycles[%0d]: got %0d want %0d", s, n, dep_of(s));
    end
    total++;
    if (bad_rdy !== 1'b0) begin
      bad++;
      $display("FAIL init_ready[%0d]: got ready=1 during sweep want 0", s);
    end
    model_init(s);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      issue(1'b0, 5'(a), 8'd0, ok);
      wait_rsp(cyc, d);
      total++;
      if (!ok || cyc !== lat_of(s) || d !== mdl[s][a]) begin
        bad++;
        $display("FAIL init_read[%0d] adr %0d: got data %0h lat %0d want %0h lat %0d", s, a, d, cyc, mdl[s][a], lat_of(s));
      end
    end
  endtask

  task automatic test_write_read;
    bit ok;
    int cyc;
    logic [7:0] d;
    cur = 1'b0;
    @(negedge clk);
    issue(1'b1, 5'd5, 8'hA5, ok);
    mdl[0][5] = 8'hA5;
    @(negedge clk);
    issue(1'b0, 5'd5, 8'd0, ok);
    wait_rsp(cyc, d);
    total++;
    if (!ok || cyc !== 1 || d !== 8'hA5) begin
      bad++;
      $display("FAIL write_read: got data %0h lat %0d want a5 lat 1", d, cyc);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] d0, d1;
    bit v0, v1;
    cur = 1'b0;
    @(negedge clk);
    issue(1'b0, 5'd10, 8'd0, ok);
    @(negedge clk);
    v0 = o_rvalid; d0 = o_rdata;
    issue(1'b0, 5'd11, 8'd0, ok);
    @(negedge clk);
    drv(1'b0, 1'b0, 5'd0, 8'd0);
    v1 = o_rvalid; d1 = o_rdata;
    total++;
    if ({v0, d0, v1, d1} !== {1'b1, 8'd1, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL back_to_back: got v%0d %0h, v%0d %0h want v1 1, v1 2", v0, d0, v1, d1);
    end
  endtask

  task automatic test_rd_wait;
    bit ok;
    logic [2:0] rdy, vld;
    logic [7:0] d;
    int n;
    cur = 1'b1;
    @(negedge clk);
    issue(1'b0, 5'd12, 8'd0, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) drv(1'b0, 1'b0, 5'd0, 8'd0);
      rdy[i] = o_ready;
      vld[i] = o_rvalid;
    end
    d = o_rdata;
    total++;
    if (!ok || rdy !== 3'b100 || vld !== 3'b100 || d !== 8'd3) begin
      bad++;
      $display("FAIL rd_wait: got ready %b valid %b data %0h want 100 100 3", rdy, vld, d);
    end
    issue(1'b0, 5'd13, 8'd0, ok);
    @(negedge clk);
    drv(1'b0, 1'b0, 5'd0, 8'd0);
    total++;
    if (!ok || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL rd_wait_accept: got ready %b want 0 after accept in rsp cycle", o_ready);
    end
    n = 1;
    while (!o_rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 3 || o_rdata !== 8'd4) begin
      bad++;
      $display("FAIL rd_wait_second: got lat %0d data %0h want 3 4", n, o_rdata);
    end
  endtask

  task automatic test_out_of_range;
    bit ok;
    int cyc;
    logic [7:0] d;
    cur = 1'b1;
    @(negedge clk);
    issue(1'b1, 5'd25, 8'h77, ok);
    @(negedge clk);
    issue(1'b0, 5'd25, 8'd0, ok);
    wait_rsp(cyc, d);
    total++;
    if (!ok || cyc !== 3 || d !== 8'd0) begin
      bad++;
      $display("FAIL oor_read: got data %0h lat %0d want 0 lat 3", d, cyc);
    end
    @(negedge clk);
    issue(1'b0, 5'd19, 8'd0, ok);
    wait_rsp(cyc, d);
    total++;
    if (!ok || d !== 8'd10) begin
      bad++;
      $display("FAIL oor_neighbour: got %0h want a", d);
    end
  endtask

  task automatic test_random(input bit s, input int cnt);
    bit ok, we;
    logic [4:0] adr;
    logic [7:0] wd, d, exp_d;
    int cyc;
    cur = s;
    for (int i = 0; i < cnt; i++) begin
      we  = 1'($urandom_range(0, 1));
      adr = 5'($urandom_range(0, 31));
      wd  = 8'($urandom);
      @(negedge clk);
      issue(we, adr, wd, ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL rand_accept[%0d]: got no ready want ready", s);
      end else if (we) begin
        if (int'(adr) < dep_of(s)) mdl[s][adr] = wd;
      end else begin
        exp_d = mdl[s][adr];
        wait_rsp(cyc, d);
        total++;
        if (cyc !== lat_of(s) || d !== exp_d) begin
          bad++;
          $display("FAIL rand_read[%0d] adr %0d: got %0h lat %0d want %0h lat %0d", s, adr, d, cyc, exp_d, lat_of(s));
        end
        @(negedge clk);
        total++;
        if (o_rvalid !== 1'b0 || o_rdata !== d) begin
          bad++;
          $display("FAIL rand_hold[%0d]: got valid %b data %0h want 0 %0h", s, o_rvalid, o_rdata, d);
        end
      end
    end
    drv(1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_reset_abort;
    bit ok, seen_v;
    int n, cyc;
    logic [7:0] d;
    cur = 1'b1;
    seen_v = 1'b0;
    @(negedge clk);
    issue(1'b0, 5'd12, 8'd0, ok);
    @(negedge clk);
    drv(1'b0, 1'b0, 5'd0, 8'd0);
    set_rst(1'b0);
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_ready, o_rvalid, o_done, o_rdata} !== 11'd0) begin
      bad++;
      $display("FAIL abort_state: got rdy/vld/done/rdata=%b want all zero", {o_ready, o_rvalid, o_done, o_rdata});
    end
    set_rst(1'b1);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
      if (o_rvalid) seen_v = 1'b1;
    end
    total++;
    if (o_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_mid_init: got init_done %b want 0", o_done);
    end
    set_rst(1'b0);
    @(posedge clk);
    @(negedge clk);
    set_rst(1'b1);
    n = 0;
    while (!o_done && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (o_rvalid) seen_v = 1'b1;
    end
    total++;
    if (n !== 20) begin
      bad++;
      $display("FAIL restart_cycles: got %0d want 20", n);
    end
    total++;
    if (seen_v !== 1'b0) begin
      bad++;
      $display("FAIL abort_rsp: got rsp_valid after reset want none");
    end
    model_init(1'b1);
    for (int a = 8; a < 22; a += 3) begin
      @(negedge clk);
      issue(1'b0, 5'(a), 8'd0, ok);
      wait_rsp(cyc, d);
      total++;
      if (!ok || d !== mdl[1][a]) begin
        bad++;
        $display("FAIL restart_read adr %0d: got %0h want %0h", a, d, mdl[1][a]);
      end
    end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity;
    bit ok;
    int cyc;
    logic [7:0] d;
    logic pe;
    cur = 1'b0;
    @(negedge clk);
    issue(1'b1, 5'd14, 8'd5, ok);
    issue(1'b1, 5'd15, 8'd6, ok);
    @(negedge clk);
    dut_a.u_arr.par_mem[14] = ~dut_a.u_arr.par_mem[14];
    issue(1'b0, 5'd14, 8'd0, ok);
    wait_rsp(cyc, d);
    pe = perr_a;
    total++;
    if (d !== 8'd5 || pe !== 1'b1) begin
      bad++;
      $display("FAIL parity_inject: got data %0h perr %b want 5 1", d, pe);
    end
    @(negedge clk);
    issue(1'b0, 5'd15, 8'd0, ok);
    wait_rsp(cyc, d);
    pe = perr_a;
    total++;
    if (d !== 8'd6 || pe !== 1'b0) begin
      bad++;
      $display("FAIL parity_clean: got data %0h perr %b want 6 0", d, pe);
    end
  endtask
`endif

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    cur = 1'b0; drv(1'b0, 1'b0, 5'd0, 8'd0);
    cur = 1'b1; drv(1'b0, 1'b0, 5'd0, 8'd0);
    test_reset_init(1'b0);
    test_reset_init(1'b1);
    test_write_read();
    test_back_to_back();
    test_rd_wait();
    test_out_of_range();
    test_random(1'b0, 200);
    test_random(1'b1, 200);
    test_reset_abort();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
